// File: rtl/l2_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// l2_ctrl_pkg
// Shared types and constants for the L2 miss scheduler.
//   sched_state_e  : scheduler FSM states
//   LINE_OFFSET_W  : byte-offset bits inside a 32 B line (forced to 0 on L2)
//   LINE_W         : refill line width in bits
//   L2_NOMINAL_LAT : typical L2 round-trip latency in clocks (informational)
// ----------------------------------------------------------------------------
package l2_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  localparam int LINE_OFFSET_W  = 5;
  localparam int LINE_W         = 256;
  localparam int L2_NOMINAL_LAT = 40;

endpackage : l2_ctrl_pkg

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Searches req upward starting at
// ptr (wrapping) and grants the first active requester.
// Ports:
//   req  in  [N]        request vector
//   ptr  in  [PW]       highest-priority index for this arbitration
//   gnt  out [N]        one-hot grant (all zero when no request)
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    logic found;
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned (which would infer a latch).
    gnt   = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (int'(ptr) + off) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/l2_miss_sched.sv
// ----------------------------------------------------------------------------
// l2_miss_sched
// Schedules L1 miss requests from NUM_REQ ports onto a single L2 request port,
// one transaction outstanding at a time, round-robin between requesters.
// Optional feature macro: L2_TIMEOUT_EN (abort WAIT after TIMEOUT_CYC clocks,
// return an all-zero line and pulse timeout_err).
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   l1_req          per-requester miss request, held until its l1_resp_valid
//   l1_addr         per-requester miss address, slice i = [i*ADDR_W +: ADDR_W]
//   l1_gnt          one-hot 1-cycle pulse: request accepted
//   l1_resp_valid   one-hot 1-cycle pulse: l1_resp_data valid for requester
//   l1_resp_data    refill line
//   req_to_l2       L2 request valid (held through l2_ready stalls)
//   l2_addr         line-aligned request address
//   l2_ready        L2 accepts on req_to_l2 && l2_ready
//   l2_resp_valid   L2 line return pulse
//   l2_resp_data    L2 line data
//   busy            high whenever the FSM is not IDLE
//   timeout_err     1-cycle abort pulse (constant 0 without L2_TIMEOUT_EN)
// ----------------------------------------------------------------------------
module l2_miss_sched
  import l2_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 16,
  parameter int LINE_W      = l2_ctrl_pkg::LINE_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        l1_req,
  input  logic [NUM_REQ*ADDR_W-1:0] l1_addr,
  output logic [NUM_REQ-1:0]        l1_gnt,
  output logic [NUM_REQ-1:0]        l1_resp_valid,
  output logic [LINE_W-1:0]         l1_resp_data,
  output logic                      req_to_l2,
  output logic [ADDR_W-1:0]         l2_addr,
  input  logic                      l2_ready,
  input  logic                      l2_resp_valid,
  input  logic [LINE_W-1:0]         l2_resp_data,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_e        state;
  logic [OWN_W-1:0]    rr_ptr;
  logic [OWN_W-1:0]    owner;
  logic [CNT_W-1:0]    lat_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   data_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [OWN_W-1:0]    arb_idx;
  logic [ADDR_W-1:0]   sel_addr;

  rr_arbiter #(.N(NUM_REQ), .PW(OWN_W)) u_arb (
    .req (l1_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  // Encode the one-hot grant and pick that requester's address slice.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = OWN_W'(i);
    end
    sel_addr = l1_addr[arb_idx*ADDR_W +: ADDR_W];
  end

  assign l2_addr      = addr_q;
  assign l1_resp_data = data_q;

`ifdef L2_TIMEOUT_EN
  logic timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  // NOTE: state registers use non-blocking (<=) assignments so every flop
  // samples the pre-edge values, independent of statement order.
  // NOTE: the line data register is reset too, so a reset mid-transaction
  // leaves no stale line visible on l1_resp_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      lat_cnt       <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      l1_gnt        <= '0;
      l1_resp_valid <= '0;
      req_to_l2     <= 1'b0;
      busy          <= 1'b0;
`ifdef L2_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; set only on their single active cycle.
      l1_gnt        <= '0;
      l1_resp_valid <= '0;
`ifdef L2_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (|l1_req) begin
            owner     <= arb_idx;
            addr_q    <= {sel_addr[ADDR_W-1:LINE_OFFSET_W], LINE_OFFSET_W'(0)};
            l1_gnt    <= arb_gnt;
            req_to_l2 <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (l2_ready) begin
            req_to_l2 <= 1'b0;
            lat_cnt   <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt != {CNT_W{1'b1}}) lat_cnt <= lat_cnt + CNT_W'(1);
          // A response on the timeout cycle wins over the abort.
          if (l2_resp_valid) begin
            data_q        <= l2_resp_data;
            l1_resp_valid <= NUM_REQ'(1) << owner;
            state         <= RESP;
          end
`ifdef L2_TIMEOUT_EN
          else if (lat_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            data_q        <= '0;
            l1_resp_valid <= NUM_REQ'(1) << owner;
            timeout_q     <= 1'b1;
            state         <= RESP;
          end
`endif
        end
        RESP: begin
          // The requester just served drops to lowest priority.
          rr_ptr <= (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + OWN_W'(1);
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : l2_miss_sched
